// File: rtl/code_update_controller.sv
// Keypad-driven passcode change controller: verifies the old code, collects and confirms a
// new one, then writes its scrambled form to the stored-code register; repeated failures lock it out.
module code_update_controller #(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        change_req,
  input  logic        abort,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic [15:0] stored_code,
  output logic        load,
  output logic [15:0] datain,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        locked
);

  typedef enum logic [2:0] {
    IDLE,
    GET_OLD,
    GET_NEW,
    GET_CONF,
    COMMIT,
    LOCKOUT
  } state_t;

  localparam logic [3:0]  MAX_FAIL_L = 4'(MAX_FAIL);
  localparam logic [15:0] LOCK_LOAD  = 16'(LOCK_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [15:0] entry, entry_nxt;
  logic [15:0] new_code, new_code_nxt;
  logic [15:0] timer, timer_nxt;
  logic [3:0]  fail_cnt, fail_nxt;
  logic        error_q, error_nxt;
  logic [15:0] full_entry;
  logic [3:0]  fail_inc;

  // Digits arrive first-to-last as d0..d3; the stored form is {d2,d0,d3,d1}.
  function automatic logic [15:0] scramble(input logic [15:0] v);
    return {v[7:4], v[15:12], v[3:0], v[11:8]};
  endfunction

  assign full_entry = {entry[11:0], digit};
  assign fail_inc   = fail_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      entry    <= 16'h0000;
      new_code <= 16'h0000;
      timer    <= 16'h0000;
      fail_cnt <= 4'd0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      entry    <= entry_nxt;
      new_code <= new_code_nxt;
      timer    <= timer_nxt;
      fail_cnt <= fail_nxt;
      error_q  <= error_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    entry_nxt    = entry;
    new_code_nxt = new_code;
    timer_nxt    = timer;
    fail_nxt     = fail_cnt;
    error_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (change_req) begin
          state_nxt = GET_OLD;
          cnt_nxt   = 2'd0;
          entry_nxt = 16'h0000;
        end
      end

      GET_OLD, GET_NEW, GET_CONF: begin
        // Abort wins over a digit strobe arriving in the same cycle.
        if (abort) begin
          state_nxt = IDLE;
          error_nxt = 1'b1;
        end else if (digit_valid) begin
          if (digit > 4'd9) begin
            state_nxt = IDLE;
            error_nxt = 1'b1;
          end else begin
            entry_nxt = full_entry;
            cnt_nxt   = cnt + 2'd1;
            if (cnt == 2'd3) begin
              entry_nxt = 16'h0000;
              if (state == GET_OLD) begin
                if (scramble(full_entry) == stored_code) begin
                  state_nxt = GET_NEW;
                  fail_nxt  = 4'd0;
                end else begin
                  error_nxt = 1'b1;
                  fail_nxt  = fail_inc;
                  if (fail_inc >= MAX_FAIL_L) begin
                    state_nxt = LOCKOUT;
                    timer_nxt = LOCK_LOAD;
                  end else begin
                    state_nxt = IDLE;
                  end
                end
              end else if (state == GET_NEW) begin
                new_code_nxt = full_entry;
                state_nxt    = GET_CONF;
              end else begin
                if (full_entry == new_code) begin
                  state_nxt = COMMIT;
                end else begin
                  state_nxt = IDLE;
                  error_nxt = 1'b1;
                end
              end
            end
          end
        end
      end

      COMMIT: state_nxt = IDLE;

      LOCKOUT: begin
        if (timer == 16'h0000) begin
          state_nxt = IDLE;
          fail_nxt  = 4'd0;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign locked = (state == LOCKOUT);
  assign load   = (state == COMMIT);
  assign done   = load;
  assign datain = load ? scramble(new_code) : 16'h0000;
  assign error  = error_q;

endmodule

// File: tb/tb_code_update_controller.sv
// Directed bench for code_update_controller: a table of single-cycle vectors plus
// hand-written sequences for lockout, fail counting and asynchronous reset.
module tb_code_update_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        change_req = 1'b0;
  logic        abort = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic [15:0] stored_code = 16'h0790;
  logic        load;
  logic [15:0] datain;
  logic        busy;
  logic        done;
  logic        error;
  logic        locked;

  int checks = 0;
  int failures = 0;

  code_update_controller #(.MAX_FAIL(3), .LOCK_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .change_req(change_req), .abort(abort),
    .digit_valid(digit_valid), .digit(digit), .stored_code(stored_code),
    .load(load), .datain(datain), .busy(busy), .done(done), .error(error), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cr;
    logic        ab;
    logic        dv;
    logic [3:0]  d;
    logic        e_load;
    logic [15:0] e_datain;
    logic        e_busy;
    logic        e_done;
    logic        e_error;
    logic        e_locked;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cr, input logic ab, input logic dv, input logic [3:0] d,
                     input logic e_load, input logic [15:0] e_datain, input logic e_busy,
                     input logic e_done, input logic e_error, input logic e_locked,
                     input string name);
    vec_t v;
    v.cr = cr; v.ab = ab; v.dv = dv; v.d = d;
    v.e_load = e_load; v.e_datain = e_datain; v.e_busy = e_busy;
    v.e_done = e_done; v.e_error = e_error; v.e_locked = e_locked; v.name = name;
    vecs.push_back(v);
  endtask

  // Shorthand for a digit strobe whose only expected effect is the busy level.
  task automatic add_digit(input logic [3:0] d, input string name);
    add(0, 0, 1, d, 0, 16'h0, 1, 0, 0, 0, name);
  endtask

  task automatic apply_stimulus(input logic cr, input logic ab, input logic dv, input logic [3:0] d);
    change_req  = cr;
    abort       = ab;
    digit_valid = dv;
    digit       = d;
    @(posedge clk);
    #1;
    change_req  = 1'b0;
    abort       = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic check_output(input string name, input logic e_load, input logic [15:0] e_datain,
                              input logic e_busy, input logic e_done, input logic e_error,
                              input logic e_locked);
    logic [20:0] got, exp;
    got = {load, datain, busy, done, error, locked};
    exp = {e_load, e_datain, e_busy, e_done, e_error, e_locked};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got load=%b datain=%h busy=%b done=%b error=%b locked=%b, expected load=%b datain=%h busy=%b done=%b error=%b locked=%b",
               name, load, datain, busy, done, error, locked,
               e_load, e_datain, e_busy, e_done, e_error, e_locked);
    end
  endtask

  task automatic check_value(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Issues change_req then the four digits of code, most significant nibble first.
  task automatic run_session(input logic [15:0] code);
    apply_stimulus(1, 0, 0, 4'd0);
    for (int i = 3; i >= 0; i--) apply_stimulus(0, 0, 1, code[i*4 +: 4]);
  endtask

  initial begin
    int n;

    // Scrambled 0790 corresponds to keyed digits 7,0,0,9.
    add(1, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, "a_start");
    add_digit(7, "a_old"); add_digit(0, "a_old"); add_digit(0, "a_old"); add_digit(9, "a_old4");
    add_digit(1, "a_new"); add_digit(2, "a_new"); add_digit(3, "a_new"); add_digit(4, "a_new4");
    add_digit(1, "a_conf"); add_digit(2, "a_conf"); add_digit(3, "a_conf");
    add(0, 0, 1, 4, 1, 16'h3142, 1, 1, 0, 0, "a_commit");
    add(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, "a_idle");

    add(1, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, "b_start");
    add_digit(7, "b_old"); add_digit(0, "b_old"); add_digit(0, "b_old"); add_digit(9, "b_old4");
    add_digit(5, "b_new"); add_digit(6, "b_new"); add_digit(7, "b_new"); add_digit(8, "b_new4");
    add_digit(5, "b_conf"); add_digit(6, "b_conf"); add_digit(7, "b_conf");
    add(0, 0, 1, 9, 0, 16'h0, 0, 0, 1, 0, "b_mismatch");
    add(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, "b_idle");

    add(1, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, "c_start");
    add_digit(7, "c_old"); add_digit(0, "c_old"); add_digit(0, "c_old"); add_digit(9, "c_old4");
    add_digit(1, "c_new"); add_digit(2, "c_new");
    add(0, 1, 1, 3, 0, 16'h0, 0, 0, 1, 0, "c_abort_with_digit");
    add(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, "c_idle");

    add(0, 0, 1, 7, 0, 16'h0, 0, 0, 0, 0, "d_idle_digit");
    add(1, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, "d_start");
    add_digit(7, "d_old");
    add(1, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, "d_cr_ignored");
    add_digit(0, "d_old"); add_digit(0, "d_old"); add_digit(9, "d_old4");
    add_digit(1, "d_new_after_cr");
    add(0, 1, 0, 0, 0, 16'h0, 0, 0, 1, 0, "d_abort");
    add(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, "d_idle");

    add(1, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, "e_start");
    add_digit(7, "e_old");
    add(0, 0, 1, 4'hA, 0, 16'h0, 0, 0, 1, 0, "e_bad_digit");
    add(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, "e_idle");

    #2;
    check_output("reset_state", 0, 16'h0, 0, 0, 0, 0);
    #10 rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].cr, vecs[i].ab, vecs[i].dv, vecs[i].d);
      check_output(vecs[i].name, vecs[i].e_load, vecs[i].e_datain, vecs[i].e_busy,
                   vecs[i].e_done, vecs[i].e_error, vecs[i].e_locked);
    end

    // Bad digits and aborts after a good old code must not count as failures;
    // a good old code clears the count.
    run_session(16'h1111);
    check_output("f_wrong1", 0, 16'h0, 0, 0, 1, 0);
    run_session(16'h1111);
    check_output("f_wrong2", 0, 16'h0, 0, 0, 1, 0);
    run_session(16'h7009);
    apply_stimulus(0, 1, 0, 0);
    check_output("f_good_then_abort", 0, 16'h0, 0, 0, 1, 0);
    run_session(16'h1111);
    check_output("f_wrong_after_clear", 0, 16'h0, 0, 0, 1, 0);
    run_session(16'h1111);
    check_output("f_wrong_second", 0, 16'h0, 0, 0, 1, 0);
    run_session(16'h1111);
    check_output("g_lock_enter", 0, 16'h0, 1, 0, 1, 1);

    // Hammer the ignored inputs while measuring the lockout length.
    n = 1;
    for (int k = 0; k < 100; k++) begin
      apply_stimulus(1, k[0], 1, 4'd0);
      if (locked) n++;
      else break;
    end
    check_value("g_lock_len", n, 16);
    check_output("g_after_lock", 0, 16'h0, 0, 0, 0, 0);
    run_session(16'h1111);
    check_output("g_fail_cleared", 0, 16'h0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0);

    // Asynchronous reset one digit before a commit.
    run_session(16'h7009);
    for (int i = 1; i <= 4; i++) apply_stimulus(0, 0, 1, 4'(i));
    for (int i = 1; i <= 3; i++) apply_stimulus(0, 0, 1, 4'(i));
    check_output("r_pre_commit", 0, 16'h0, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_output("r_async_commit", 0, 16'h0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    apply_stimulus(0, 0, 1, 4'd4);
    check_output("r_no_load", 0, 16'h0, 0, 0, 0, 0);

    // Asynchronous reset in lockout also clears the fail count.
    for (int s = 0; s < 3; s++) run_session(16'h2222);
    apply_stimulus(0, 0, 0, 0);
    check_output("r_in_lock", 0, 16'h0, 1, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1 check_output("r_async_lock", 0, 16'h0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    run_session(16'h1111);
    check_output("r_fail_cleared", 0, 16'h0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_update_controller.md
CODE_UPDATE_CONTROLLER -- requirements
Module: code_update_controller

Interface
REQ-001 Parameter MAX_FAIL, default 3: consecutive wrong old-code entries that trigger lockout; legal range 1..15.
REQ-002 Parameter LOCK_CYCLES, default 16: lockout duration in clk cycles; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 change_req  input  1  one-cycle pulse that starts a passcode-change session.
REQ-006 abort  input  1  level; cancels any open session.
REQ-007 digit_valid  input  1  one-cycle strobe qualifying digit.
REQ-008 digit  input  4  keypad digit; legal values 0..9.
REQ-009 stored_code  input  16  scrambled passcode currently held by the stored-code register.
REQ-010 load  output  1  one-cycle write strobe to the stored-code register.
REQ-011 datain  output  16  scrambled new passcode; valid whenever load=1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on successful commit.
REQ-014 error  output  1  one-cycle pulse on any failed or aborted session.
REQ-015 locked  output  1  high throughout lockout.

Function
REQ-016 FSM states: IDLE, GET_OLD, GET_NEW, GET_CONF, COMMIT, LOCKOUT.
REQ-017 Each entry phase collects exactly 4 digits; first digit stored in bits [15:12], fourth in [3:0]; 2-bit digit counter per phase.
REQ-018 Scramble function S(d0,d1,d2,d3) = {d2,d0,d3,d1} (nibbles, MSB first); the same S is used for both comparison and storage.
REQ-019 IDLE: change_req=1 -> GET_OLD, clear digit counter; digit_valid ignored in IDLE.
REQ-020 GET_OLD: after the 4th digit, if S(entry)==stored_code -> GET_NEW and clear fail counter; else increment fail counter, pulse error, -> IDLE, or -> LOCKOUT when fail counter reaches MAX_FAIL.
REQ-021 GET_NEW: after the 4th digit -> GET_CONF; new entry held in a 16-bit register.
REQ-022 GET_CONF: after the 4th digit, if match with new entry -> COMMIT; else pulse error, -> IDLE (fail counter unchanged).
REQ-023 COMMIT: load=1 and datain=S(new entry) for exactly one cycle, done=1 in the same cycle, -> IDLE next cycle.
REQ-024 LOCKOUT: locked=1, 16-bit timer loaded with LOCK_CYCLES-1 on entry, decremented each cycle; at 0 -> IDLE, fail counter cleared; change_req, digits and abort ignored.
REQ-025 A digit >9 in any entry phase: pulse error, -> IDLE, does not count as a fail.
REQ-026 abort=1 in GET_OLD, GET_NEW or GET_CONF: -> IDLE next cycle, pulse error; abort has priority over a simultaneous digit_valid.
REQ-027 change_req outside IDLE is ignored.
REQ-028 load is never asserted outside COMMIT; datain=16'h0000 when load=0.
REQ-029 done and error are never high in the same cycle.

Reset
REQ-030 rst_n=0 forces, without waiting for clk: state IDLE, all counters and entry registers 0, load=0, datain=0, busy=0, done=0, error=0, locked=0.
REQ-031 Reset mid-session or mid-lockout discards the session; no load is issued; the fail counter is cleared.
REQ-032 First state change occurs on the first rising clk edge after rst_n deasserts.

Verification
REQ-033 stored_code=16'h0790; change_req; digits 7,0,0,9; new 1,2,3,4; confirm 1,2,3,4 -> one-cycle load with datain=16'h3142, done=1 in the same cycle, then IDLE.
REQ-034 stored_code=16'h0790; three sessions each entering 1,1,1,1 -> error pulse per session; after the third, locked=1 for exactly 16 cycles, then IDLE.
REQ-035 Correct old code; new 5,6,7,8; confirm 5,6,7,9 -> error pulse, no load, busy=0 next cycle.
REQ-036 In GET_NEW after 2 digits, abort=1 with digit_valid=1 in the same cycle -> IDLE, error pulse, no load.
REQ-037 Digit value 4'hA during GET_OLD -> error pulse, IDLE, fail counter unchanged.
REQ-038 rst_n pulsed low asynchronously during COMMIT setup or LOCKOUT -> all outputs 0 immediately, no load.
